// File: rtl/ext_mem_controller.sv
// Backing-store word memory with a programmable accept-to-ack latency and a one-cycle ack.
// Define EXT_MEM_BOUNDS_EN to flag and suppress out-of-range accesses; otherwise addresses wrap.
module ext_mem_controller #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_addr,
  input  logic                 en_ext_mem_re,
  input  logic                 en_ext_mem_wr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 mem_ready,
  output logic                 mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state;
  logic [7:0]           cnt;
  logic                 op_wr;
  logic                 op_oob;
  logic [AW-1:0]        op_idx;
  logic [WORD_SIZE-1:0] op_wdata;
  logic                 err_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic req;
  logic addr_oob;
  logic finish;
  logic commit;
  logic unused_addr;

  assign req = en_ext_mem_re | en_ext_mem_wr;

`ifdef EXT_MEM_BOUNDS_EN
  assign addr_oob = |mem_addr[31:AW+2];
`else
  // Upper bits are dropped so accesses wrap modulo DEPTH words.
  assign addr_oob = 1'b0;
`endif
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // The request must still be held on the edge that completes the access.
  assign finish = (state == StBusy) && req && (cnt == 8'd0);
  assign commit = finish && op_wr && !op_oob;

  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      mem[op_idx] <= op_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= 8'd0;
      data_out  <= '0;
      mem_ready <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err_q     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req) begin
            state    <= StBusy;
            cnt      <= 8'(LATENCY - 1);
            op_wr    <= en_ext_mem_wr;
            op_oob   <= addr_oob;
            op_idx   <= mem_addr[AW+1:2];
            op_wdata <= data_in;
          end
        end
        StBusy: begin
          if (!req) begin
            state <= StIdle;
          end else if (cnt == 8'd0) begin
            state     <= StDone;
            mem_ready <= 1'b1;
            err_q     <= op_oob;
            // Reads and writes both return the pre-write word.
            data_out  <= op_oob ? WORD_SIZE'(32'hDEADBEEF) : mem[op_idx];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign mem_err = err_q;

endmodule
